wshb_frame_reader: RTL and testbench

- Wishbone initiator that fetches a frame buffer from SDRAM in raster order and delivers it as a pixel stream with valid/ready flow control.
- Sits between the SDRAM Wishbone bus driven by hw_support and the future video output stage.
- Replaces the idle tie-offs currently driven on the SDRAM bus in Top.
- Holds an internal prefetch FIFO so that SDRAM latency is hidden from the pixel consumer.

---
 rtl/wshb_if.sv | 27 ++
 rtl/wshb_frame_reader.sv | 113 +++++++++++
 tb/tb_wshb_frame_reader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_if.sv
// Wishbone B4 classic bus bundle; the initiator drives the master modport.
interface wshb_if #(
  parameter int DATA_BYTES = 4
) ();
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output adr, dat_ms, sel, cti, bte, cyc, stb, we,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  adr, dat_ms, sel, cti, bte, cyc, stb, we,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_frame_reader.sv
// Raster-order frame buffer reader: Wishbone classic reads into a FWFT prefetch FIFO.
// A word acked at edge N is on pix_valid after N; requests stall while the FIFO is full.
module wshb_frame_reader #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wshb_if.master      wshb_ifm,
  input  logic        enable,
  output logic [31:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        bus_err
);
  localparam int            NPIX     = HDISP * VDISP;
  localparam int            IW       = $clog2(NPIX + 1);
  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [32:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          req;
  logic          term;
  logic          pop;

  // Extra pointer bit distinguishes full from empty at equal addresses.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign req        = (state == FETCH) && !fifo_full;
  assign term       = req && (wshb_ifm.ack || wshb_ifm.err);
  assign pop        = pix_valid && pix_ready;

  assign wshb_ifm.cyc    = req;
  assign wshb_ifm.stb    = req;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = '1;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.dat_ms = '0;
  assign wshb_ifm.adr    = BASE_ADDR + (32'(idx) << 2);

  assign pix_valid = !fifo_empty;
  assign pix_data  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[AW-1:0]][31:0];
  assign pix_sof   = fifo_empty ? 1'b0  : fifo_mem[rd_ptr[AW-1:0]][32];
  assign busy      = (state != IDLE);

  // An err response still occupies its pixel slot so the raster stays aligned.
  always_ff @(posedge sys_clk) begin
    if (term) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {idx == '0, wshb_ifm.ack ? wshb_ifm.dat_sm[31:0] : 32'h0};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (term) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      idx     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (req && wshb_ifm.err && !wshb_ifm.ack) bus_err <= 1'b1;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= FETCH;
            idx   <= '0;
          end
        end
        FETCH: begin
          if (term) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (!enable) state <= FLUSH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (fifo_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst && req) begin
      assert ($onehot0({wshb_ifm.ack, wshb_ifm.err, wshb_ifm.rty}));
    end
  end
endmodule

// File: tb/tb_wshb_frame_reader.sv
// Randomised bench: Wishbone slave model feeds an expected-pixel queue, a monitor checks the stream.
module tb_wshb_frame_reader;
  localparam int          HD    = 4;
  localparam int          VD    = 2;
  localparam int          NPIX  = HD * VD;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h100;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        enable = 1'b0;
  logic        pix_ready = 1'b0;
  logic [31:0] pix_data;
  logic        pix_sof;
  logic        pix_valid;
  logic        busy;
  logic        bus_err;

  wshb_if #(.DATA_BYTES(4)) wb ();

  wshb_frame_reader #(
    .HDISP(HD), .VDISP(VD), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wshb_ifm(wb), .enable(enable),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .bus_err(bus_err)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  int          pix_cnt = 0;
  int          sof_cnt = 0;
  int          ack_cnt = 0;
  int          resp_cnt = 0;
  int          term_cnt[NPIX];
  int          rty_left[NPIX];
  int          err_idx = -1;
  int          max_delay = 0;
  logic [31:0] salt = 32'h5A5A_1234;
  bit          wrap_chk = 0;
  bit          wrap_pending = 0;
  bit          err_pending = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Slave model: answers each request after a random wait with ack, err or rty per the test setup.
  initial begin : slave
    bit          in_req;
    bit          rst_edge;
    int          wait_left;
    int          exp_idx;
    logic [31:0] req_adr;
    in_req = 0; wait_left = 0; exp_idx = 0; req_adr = '0;
    wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0; wb.dat_sm = '0;
    forever begin
      @(posedge sys_clk);
      rst_edge = sys_rst;
      #1;
      wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0; wb.dat_sm = $urandom;
      if (rst_edge) begin
        in_req = 0; exp_idx = 0; wrap_pending = 0; err_pending = 0;
        continue;
      end
      if (err_pending) begin
        chk("bus_err_set", bus_err, 1);
        err_pending = 0;
      end
      if (wrap_pending) begin
        chk("wrap_no_gap", {wb.stb, wb.adr}, {1'b1, BASE});
        wrap_pending = 0;
      end
      if (wb.stb) begin
        if (!in_req) begin
          in_req = 1;
          req_adr = wb.adr;
          wait_left = $urandom_range(0, max_delay);
          chk("adr_seq", wb.adr, BASE + 32'(exp_idx) * 4);
          chk("bus_fields", {wb.cyc, wb.we, wb.sel, wb.cti, wb.bte, wb.dat_ms},
              {1'b1, 1'b0, 4'hF, 3'b000, 2'b00, 32'h0});
        end else begin
          chk("adr_hold", wb.adr, req_adr);
        end
        if (wait_left > 0) begin
          wait_left--;
        end else begin
          in_req = 0;
          term_cnt[exp_idx]++;
          resp_cnt++;
          if (exp_idx == err_idx) begin
            wb.err = 1'b1;
            exp_q.push_back({exp_idx == 0, 32'h0});
            err_pending = 1;
          end else if (rty_left[exp_idx] > 0) begin
            wb.rty = 1'b1;
            rty_left[exp_idx]--;
          end else begin
            wb.ack = 1'b1;
            wb.dat_sm = mem_word(wb.adr);
            exp_q.push_back({exp_idx == 0, wb.dat_sm});
            ack_cnt++;
          end
          if (!wb.rty) begin
            if (wrap_chk && exp_idx == NPIX - 1) begin
              wrap_pending = 1;
              wrap_chk = 0;
            end
            exp_idx = (exp_idx + 1) % NPIX;
          end
        end
      end else if (in_req) begin
        chk("stb_held", wb.stb, 1);
        in_req = 0;
      end
    end
  end

  // Monitor: pops expected pixels on each transfer and checks hold stability under backpressure.
  initial begin : monitor
    bit          held_v;
    logic [32:0] held;
    logic [32:0] e;
    held_v = 0; held = '0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst) begin
        held_v = 0;
        continue;
      end
      if (held_v && pix_valid) chk("pix_hold", {pix_sof, pix_data}, held);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_extra: got %0h with no expected pixel", {pix_sof, pix_data});
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {pix_sof, pix_data}, e);
        end
        pix_cnt++;
        if (pix_sof) sof_cnt++;
        held_v = 0;
      end else if (pix_valid) begin
        held_v = 1;
        held = {pix_sof, pix_data};
      end else begin
        held_v = 0;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_counts();
    pix_cnt = 0; sof_cnt = 0; ack_cnt = 0; resp_cnt = 0;
    for (int i = 0; i < NPIX; i++) begin
      term_cnt[i] = 0;
      rty_left[i] = 0;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    chk("reset_state", {wb.cyc, wb.stb, pix_valid, pix_sof, pix_data, busy, bus_err}, 0);
    sys_rst = 1'b0;
    exp_q.delete();
    err_idx = -1; max_delay = 0; wrap_chk = 0;
    clear_counts();
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic run_until_idle(input string name, input int max_cyc, input bit rnd,
                                input int exp_pix, input int exp_sof);
    bit done;
    done = 0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      tick();
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
      if (!busy && !pix_valid) done = 1;
    end
    chk({name, "_done"}, done, 1);
    pix_ready = 1'b1;
    chk({name, "_pix_cnt"}, pix_cnt, exp_pix);
    chk({name, "_sof_cnt"}, sof_cnt, exp_sof);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    // Basic frame
    do_reset();
    pix_ready = 1'b1;
    pulse_enable();
    run_until_idle("basic", 200, 0, NPIX, 1);
    tick(); tick();
    chk("basic_idle_bus", {busy, wb.cyc, wb.stb}, 0);

    // Backpressure: FIFO fills, request stops at the fifth word
    do_reset();
    pix_ready = 1'b0;
    pulse_enable();
    for (int i = 0; i < 15; i++) tick();
    chk("bp_acks", ack_cnt, DEPTH);
    chk("bp_stall", {wb.stb, wb.adr}, {1'b0, BASE + 32'h10});
    chk("bp_busy", busy, 1);
    pix_ready = 1'b1;
    run_until_idle("bp", 200, 0, NPIX, 1);

    // Continuous run over two frames
    do_reset();
    salt = $urandom;
    pix_ready = 1'b1;
    wrap_chk = 1;
    enable = 1'b1;
    for (int i = 0; i < 200 && resp_cnt < NPIX + 1; i++) tick();
    enable = 1'b0;
    run_until_idle("cont", 200, 0, 2 * NPIX, 2);
    chk("cont_wrap_seen", wrap_chk, 0);

    // Retry twice on 0x108, err on 0x110
    do_reset();
    rty_left[2] = 2;
    err_idx = 4;
    pix_ready = 1'b1;
    pulse_enable();
    run_until_idle("rtyerr", 300, 0, NPIX, 1);
    chk("rty_reissue", term_cnt[2], 3);
    chk("bus_err_sticky", bus_err, 1);

    // Wait states and random backpressure
    do_reset();
    max_delay = 5;
    for (int f = 0; f < 3; f++) begin
      salt = $urandom;
      clear_counts();
      pulse_enable();
      run_until_idle("wait", 1500, 1, NPIX, 1);
    end

    // Reset mid-frame
    do_reset();
    err_idx = 1;
    pix_ready = 1'b0;
    pulse_enable();
    for (int i = 0; i < 60 && ack_cnt < 3; i++) tick();
    chk("mid_acks_reached", ack_cnt >= 3, 1);
    chk("mid_err_before", bus_err, 1);
    sys_rst = 1'b1;
    tick();
    chk("mid_reset", {wb.cyc, wb.stb, pix_valid, busy, bus_err}, 0);
    sys_rst = 1'b0;
    exp_q.delete();
    err_idx = -1;
    clear_counts();
    pix_ready = 1'b1;
    pulse_enable();
    run_until_idle("restart", 200, 0, NPIX, 1);
    chk("restart_no_err", bus_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
